// File: rtl/retire_port_unit.sv
// Retire-side observation port: instruction count, last result, sticky halt on the addi/jalr sequence.
// Latency: one cycle, registered outputs. Accepts one retirement per cycle with no backpressure; input is ignored once halted.
module retire_port_unit #(
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] HALT_I0   = 32'h00c00093,
    parameter logic [31:0] HALT_I1   = 32'h00008067
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RET_VALID,
    input  logic [31:0]          RET_INST,
    input  logic                 RET_RF_WE,
    input  logic [31:0]          RET_RF_WD,
    input  logic                 RET_IS_BRANCH,
    input  logic                 RET_BR_TAKEN,
    input  logic                 RET_IS_STORE,
    input  logic [31:0]          RET_ST_ADDR,
    output logic [CNT_WIDTH-1:0] NUM_INST,
    output logic [31:0]          OUTPUT_PORT,
    output logic                 HALT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [31:0]          out_q;
    logic                 halt_q;
    logic                 retire;

    assign retire = RET_VALID && !halt_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            halt_q  <= 1'b0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_ONE;

            if (RET_IS_STORE)
                out_q <= RET_ST_ADDR;
            else if (RET_IS_BRANCH)
                out_q <= {31'b0, RET_BR_TAKEN};
            else if (RET_RF_WE)
                out_q <= RET_RF_WD;

            // Bubbles never reach here, so ARMED survives gaps between the two halt instructions.
            case (state_q)
                IDLE: begin
                    if (RET_INST == HALT_I0)
                        state_q <= ARMED;
                end
                ARMED: begin
                    if (RET_INST == HALT_I1) begin
                        state_q <= HALTED;
                        halt_q  <= 1'b1;
                    end else if (RET_INST != HALT_I0) begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign NUM_INST    = cnt_q;
    assign OUTPUT_PORT = out_q;
    assign HALT        = halt_q;

endmodule

// File: tb/tb_retire_port_unit.sv
module tb_retire_port_unit;

    localparam logic [31:0] I0   = 32'h00c00093;
    localparam logic [31:0] I1   = 32'h00008067;
    localparam logic [31:0] ADDI = 32'h00100093;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vld;
    logic [31:0] inst;
    logic        we;
    logic [31:0] wd;
    logic        br;
    logic        tk;
    logic        st;
    logic [31:0] sa;

    logic [31:0] num_inst;
    logic [3:0]  num_inst_n;
    logic [31:0] out_w, out_n;
    logic        halt_w, halt_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retire_port_unit #(.CNT_WIDTH(32)) dut_w (
        .CLK(clk), .RSTn(rstn), .RET_VALID(vld), .RET_INST(inst),
        .RET_RF_WE(we), .RET_RF_WD(wd), .RET_IS_BRANCH(br), .RET_BR_TAKEN(tk),
        .RET_IS_STORE(st), .RET_ST_ADDR(sa),
        .NUM_INST(num_inst), .OUTPUT_PORT(out_w), .HALT(halt_w)
    );

    retire_port_unit #(.CNT_WIDTH(4)) dut_n (
        .CLK(clk), .RSTn(rstn), .RET_VALID(vld), .RET_INST(inst),
        .RET_RF_WE(we), .RET_RF_WD(wd), .RET_IS_BRANCH(br), .RET_BR_TAKEN(tk),
        .RET_IS_STORE(st), .RET_ST_ADDR(sa),
        .NUM_INST(num_inst_n), .OUTPUT_PORT(out_n), .HALT(halt_n)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        vld;
        logic [31:0] inst;
        logic        we;
        logic [31:0] wd;
        logic        br;
        logic        tk;
        logic        st;
        logic [31:0] sa;
        logic [31:0] e_cnt;
        logic [31:0] e_out;
        logic        e_halt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] cnt;
        logic [31:0] out;
        logic        halt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input string name, input logic r, input logic v,
                                input logic [31:0] i, input logic w, input logic [31:0] d,
                                input logic b, input logic t, input logic s, input logic [31:0] a,
                                input logic [31:0] ec, input logic [31:0] eo, input logic eh);
        vec_t x;
        x.name = name; x.rst_n = r; x.vld = v; x.inst = i; x.we = w; x.wd = d;
        x.br = b; x.tk = t; x.st = s; x.sa = a;
        x.e_cnt = ec; x.e_out = eo; x.e_halt = eh;
        return x;
    endfunction

    task automatic check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry for DUT output");
            return;
        end
        e = sb.pop_front();
        if (num_inst !== e.cnt || out_w !== e.out || halt_w !== e.halt ||
            num_inst_n !== e.cnt[3:0] || out_n !== e.out || halt_n !== e.halt) begin
            errors++;
            $display("FAIL %s: got cnt=%0h cnt4=%0h out=%0h out4=%0h halt=%0b halt4=%0b, expected cnt=%0h cnt4=%0h out=%0h halt=%0b",
                     e.name, num_inst, num_inst_n, out_w, out_n, halt_w, halt_n,
                     e.cnt, e.cnt[3:0], e.out, e.halt);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rstn = v.rst_n; vld = v.vld; inst = v.inst; we = v.we; wd = v.wd;
        br = v.br; tk = v.tk; st = v.st; sa = v.sa;
        e.name = v.name; e.cnt = v.e_cnt; e.out = v.e_out; e.halt = v.e_halt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        rstn = 1'b0; vld = 1'b0; inst = '0; we = 1'b0; wd = '0;
        br = 1'b0; tk = 1'b0; st = 1'b0; sa = '0;

        //           name           rst vld inst  we wd         br tk st sa          cnt out         halt
        tbl.push_back(mk("reset",     0, 0, ADDI, 0, 32'h0,     0, 0, 0, 32'h0,     0, 32'h0,     0));
        tbl.push_back(mk("idle",      1, 0, ADDI, 1, 32'h99,    0, 0, 0, 32'h0,     0, 32'h0,     0));
        tbl.push_back(mk("addi_eec",  1, 1, ADDI, 1, 32'h0eec,  0, 0, 0, 32'h0,     1, 32'h0eec,  0));
        tbl.push_back(mk("bubble1",   1, 0, ADDI, 1, 32'h55,    0, 0, 0, 32'h0,     1, 32'h0eec,  0));
        tbl.push_back(mk("addi_0",    1, 1, ADDI, 1, 32'h0,     0, 0, 0, 32'h0,     2, 32'h0,     0));
        tbl.push_back(mk("bubble2",   1, 0, ADDI, 1, 32'h66,    0, 0, 0, 32'h0,     2, 32'h0,     0));
        tbl.push_back(mk("bubble3",   1, 0, ADDI, 0, 32'h0,     0, 0, 0, 32'h0,     2, 32'h0,     0));
        tbl.push_back(mk("addi_1",    1, 1, ADDI, 1, 32'h1,     0, 0, 0, 32'h0,     3, 32'h1,     0));
        tbl.push_back(mk("bubble4",   1, 0, ADDI, 0, 32'h0,     0, 0, 0, 32'h0,     3, 32'h1,     0));
        tbl.push_back(mk("store_pri", 1, 1, ADDI, 1, 32'h1234,  0, 0, 1, 32'h0f00,  4, 32'h0f00,  0));
        tbl.push_back(mk("br_taken",  1, 1, ADDI, 0, 32'h0,     1, 1, 0, 32'h0,     5, 32'h1,     0));
        tbl.push_back(mk("br_not",    1, 1, ADDI, 1, 32'hdead,  1, 0, 0, 32'h0,     6, 32'h0,     0));
        tbl.push_back(mk("no_write",  1, 1, ADDI, 0, 32'hbeef,  0, 0, 0, 32'h0,     7, 32'h0,     0));
        tbl.push_back(mk("halt_i0",   1, 1, I0,   1, 32'hc,     0, 0, 0, 32'h0,     8, 32'hc,     0));
        tbl.push_back(mk("armed_gap1",1, 0, ADDI, 0, 32'h0,     0, 0, 0, 32'h0,     8, 32'hc,     0));
        tbl.push_back(mk("armed_gap2",1, 0, ADDI, 0, 32'h0,     0, 0, 0, 32'h0,     8, 32'hc,     0));
        tbl.push_back(mk("halt_i1",   1, 1, I1,   1, 32'h2c,    0, 0, 0, 32'h0,     9, 32'h2c,    1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk("halted_hold", 1, 1, ADDI, 1, 32'h77, 0, 0, 1, 32'h500, 9, 32'h2c, 1));
        tbl.push_back(mk("reset2",    0, 1, ADDI, 1, 32'h88,    0, 0, 0, 32'h0,     0, 32'h0,     0));
        tbl.push_back(mk("seq_i0",    1, 1, I0,   1, 32'hc,     0, 0, 0, 32'h0,     1, 32'hc,     0));
        tbl.push_back(mk("disarm",    1, 1, ADDI, 1, 32'h5,     0, 0, 0, 32'h0,     2, 32'h5,     0));
        tbl.push_back(mk("i1_no_halt",1, 1, I1,   0, 32'h0,     0, 0, 0, 32'h0,     3, 32'h5,     0));
        tbl.push_back(mk("seq_i0a",   1, 1, I0,   1, 32'hc,     0, 0, 0, 32'h0,     4, 32'hc,     0));
        tbl.push_back(mk("seq_i0b",   1, 1, I0,   1, 32'hc,     0, 0, 0, 32'h0,     5, 32'hc,     0));
        tbl.push_back(mk("seq_i1",    1, 1, I1,   0, 32'h0,     0, 0, 0, 32'h0,     6, 32'hc,     1));

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k]);

        // Counter wrap: the 4-bit instance reads 1..15 then 0 while the 32-bit one keeps going.
        apply(mk("wrap_reset", 0, 0, ADDI, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        for (int k = 1; k <= 16; k++)
            apply(mk("wrap_step", 1, 1, ADDI, 1, 32'(k), 0, 0, 0, 32'h0, 32'(k), 32'(k), 0));

        // Reset wins over a concurrent retirement and drops the ARMED state.
        apply(mk("arm_reset", 0, 0, ADDI, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        for (int k = 1; k <= 32'h45; k++)
            apply(mk("fill", 1, 1, ADDI, 1, 32'h100 + 32'(k), 0, 0, 0, 32'h0, 32'(k), 32'h100 + 32'(k), 0));
        apply(mk("arm_i0",    1, 1, I0, 1, 32'hc,  0, 0, 0, 32'h0, 32'h46, 32'hc, 0));
        apply(mk("rst_vs_vld",0, 1, I1, 1, 32'h9,  0, 0, 0, 32'h0, 0,      32'h0, 0));
        apply(mk("lone_i1",   1, 1, I1, 1, 32'h3,  0, 0, 0, 32'h0, 1,      32'h3, 0));
        apply(mk("tail_idle", 1, 0, I1, 1, 32'h4,  0, 0, 0, 32'h0, 1,      32'h3, 0));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/retire_port_unit.md
# retire_port_unit

Retirement-side producer of the core's observation interface: counts retired instructions on NUM_INST, publishes each retired instruction's architectural result on OUTPUT_PORT, and raises HALT on the halt sequence. Sits inside the RISCV core top, fed by the writeback/retire stage; its three outputs drive the core's NUM_INST, OUTPUT_PORT and HALT ports, which the checkpoint testbenches sample on every rising CLK edge.

## Interface
- CNT_WIDTH, 32, width of NUM_INST
- HALT_I0, 32'h00c00093, first halt-sequence instruction (addi x1,x0,12)
- HALT_I1, 32'h00008067, second halt-sequence instruction (jalr x0,0(x1))

- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  reset, synchronous, active-low
- RET_VALID  in  1  an instruction retires this cycle
- RET_INST  in  32  encoding of the retiring instruction
- RET_RF_WE  in  1  retiring instruction writes the register file
- RET_RF_WD  in  32  register write data
- RET_IS_BRANCH  in  1  retiring instruction is a conditional branch
- RET_BR_TAKEN  in  1  branch outcome
- RET_IS_STORE  in  1  retiring instruction is a store
- RET_ST_ADDR  in  32  store effective address
- NUM_INST  out  CNT_WIDTH  retired-instruction count
- OUTPUT_PORT  out  32  result of the last retired instruction
- HALT  out  1  halt sequence retired; sticky

## Operation
- Reset (RSTn=0 at a rising edge): NUM_INST=0, OUTPUT_PORT=0, HALT=0, FSM=IDLE. Reset overrides every other input, including a concurrent RET_VALID.
- A retire event is RET_VALID=1 while HALT=0. With RET_VALID=0, or once HALT=1, all state holds and all other inputs are ignored.
- On each retire event, NUM_INST <= NUM_INST+1, modulo 2^CNT_WIDTH (all-ones wraps to 0).
- OUTPUT_PORT update on a retire event, first match wins:
  - RET_IS_STORE: RET_ST_ADDR.
  - RET_IS_BRANCH: {31'b0, RET_BR_TAKEN}.
  - RET_RF_WE: RET_RF_WD.
  - Otherwise: hold.
- Halt FSM, advanced only on retire events:
  - IDLE: RET_INST==HALT_I0 -> ARMED; else stay in IDLE.
  - ARMED: RET_INST==HALT_I1 -> HALTED; RET_INST==HALT_I0 -> stay in ARMED; anything else -> IDLE.
  - HALTED: HALT=1; exit only by reset.
- The HALT_I1 retirement is itself counted and updates OUTPUT_PORT by the normal rules.
- Bubbles between HALT_I0 and HALT_I1 do not disarm the FSM.

## Timing
- All outputs are registered. A retire event at edge N is visible on NUM_INST, OUTPUT_PORT and HALT after edge N, and is sampled by the bench at edge N+1.
- HALT rises in the same cycle that NUM_INST shows the HALT_I1 count.
- Throughput is one retirement per cycle. No stall output.
- Reset deasserted mid-run: the FSM restarts in IDLE; a prior ARMED state is lost.

## Test plan
- Reset, then 3 RET_VALID pulses on non-consecutive cycles carrying addi with RF_WE=1, WD=0x0eec, 0x0000, 0x0001 -> NUM_INST reads 1, 2, 3 with OUTPUT_PORT 0x0eec, 0x0000, 0x0001; values hold during bubbles.
- Retire one instruction with STORE=1, ST_ADDR=0x0f00, RF_WE=1, WD=0x1234 -> OUTPUT_PORT=0x0f00. Then retire a branch, taken=1 -> OUTPUT_PORT=0x1. Then a branch, taken=0 -> 0x0. Then an instruction with RF_WE=0 and not a branch or store -> OUTPUT_PORT stays 0x0.
- Retire HALT_I0, 2 bubble cycles, then HALT_I1 -> HALT=1 on the cycle NUM_INST increments by 2 overall. Then 5 more retirements -> NUM_INST, OUTPUT_PORT and HALT all unchanged.
- Retire HALT_I0, then an addi, then HALT_I1 -> HALT stays 0. Retire HALT_I0, HALT_I0, HALT_I1 -> HALT=1.
- CNT_WIDTH=4: 16 retirements from reset -> NUM_INST steps 1..15, then wraps to 0.
- Assert RSTn=0 together with RET_VALID=1 while FSM=ARMED and NUM_INST=0x46 -> next cycle NUM_INST=0, OUTPUT_PORT=0, HALT=0. A following HALT_I1 alone does not halt.
